// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial UART receiver
//
// Recovers frames of 1 start bit, 8 data bits (LSB first) and 1 stop bit from
// the asynchronous uart_rxd line. Each good byte is presented on uart_data_out
// together with a one-cycle rx_done pulse. A frame whose stop bit samples low
// raises a one-cycle frame_err pulse instead, and the byte is discarded.
//
// Parameters
//   CLK_F     system clock frequency in Hz
//   UART_BPS  baud rate
//   CLK_GOAL  system clock cycles per bit
//   HALF      in-bit sample point (cycles after the bit boundary)
//
// Ports
//   clk            system clock, all logic on posedge
//   rst_n          asynchronous reset, active low
//   uart_rxd       serial line, asynchronous to clk, idles high
//   uart_data_out  last correctly received byte, held until the next good frame
//   rx_done        one-cycle pulse: good frame received, uart_data_out updated
//   frame_err      one-cycle pulse: stop bit sampled low, byte discarded
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned CLK_F    = 50_000_000,
  parameter int unsigned UART_BPS = 115200,
  parameter int unsigned CLK_GOAL = CLK_F / UART_BPS,
  parameter int unsigned HALF     = CLK_GOAL / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_data_out,
  output logic       rx_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Synchronizer chain; rxd_0 may go metastable, rxd_1/rxd_2 are safe to use.
  logic rxd_0_q, rxd_1_q, rxd_2_q;

  state_e      state_q, state_d;
  logic [31:0] clk_count_q, clk_count_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic       start_edge;
  logic       sample_tick;
  logic       bit_end;
  logic [2:0] data_pos;

  // Falling edge seen on the synchronized line; requires rxd_2 high, so a line
  // stuck low (break) cannot retrigger a frame until it has returned high.
  assign start_edge  = rxd_2_q & ~rxd_1_q;
  assign sample_tick = (clk_count_q == HALF);
  assign bit_end     = (clk_count_q == CLK_GOAL - 1);
  // Data bits occupy bit_idx 1..8 and land in shift_q[0..7].
  assign data_pos    = 3'(bit_idx_q - 4'd1);

  // NOTE: every flop here is a plain register (no memory array), so all of
  // them take a defined reset value, including the synchronizer which resets
  // to the idle-high line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_0_q     <= 1'b1;
      rxd_1_q     <= 1'b1;
      rxd_2_q     <= 1'b1;
      state_q     <= IDLE;
      clk_count_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // this is what makes the three-stage chain actually three stages deep.
      rxd_0_q     <= uart_rxd;
      rxd_1_q     <= rxd_0_q;
      rxd_2_q     <= rxd_1_q;
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_d     = state_q;
    clk_count_d = clk_count_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // Bit timing runs in every active state.
    if (state_q != IDLE) begin
      if (bit_end) begin
        clk_count_d = '0;
        bit_idx_d   = bit_idx_q + 4'd1;
      end else begin
        clk_count_d = clk_count_q + 32'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start_edge) state_d = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (sample_tick && rxd_1_q) state_d = IDLE;
        else if (bit_end)           state_d = DATA;
      end
      DATA: begin
        if (sample_tick) shift_d[data_pos] = rxd_1_q;
        if (bit_end && (bit_idx_q == 4'd8)) state_d = STOP;
      end
      STOP: begin
        // Leave at mid stop bit, half a bit early, so a back-to-back start
        // edge right at the end of the stop bit is not missed.
        if (sample_tick) begin
          if (rxd_1_q) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counters sit at zero whenever the machine is (or is about to be) idle,
    // so the first START cycle always begins from clk_count = 0.
    if (state_d == IDLE) begin
      clk_count_d = '0;
      bit_idx_d   = '0;
    end
  end

  assign uart_data_out = data_q;
  assign rx_done       = done_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx at default bit timing (434 cyc/bit)
//
// The stimulus process drives 8N1 frames and pushes the expected result
// (kind, data, cycle of the pulse) into a queue; the monitor pops and compares
// whenever rx_done or frame_err is seen.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int unsigned CLK_GOAL = 434;
  // start_edge two cycles after the line changes, pulse 9*434+217+2 after that
  localparam int unsigned PULSE_LAT = 2 + 9 * CLK_GOAL + CLK_GOAL / 2 + 2;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] uart_data_out;
  logic       rx_done;
  logic       frame_err;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb_q[$];
  logic [7:0]  last_good = 8'h00;

  uart_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (uart_rxd),
    .uart_data_out(uart_data_out),
    .rx_done      (rx_done),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Drives one frame; each bit lasts exactly CLK_GOAL cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    exp_t e;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      uart_rxd = bits[i];
      if (i == 0) begin
        e.is_err = ~stop;
        e.data   = stop ? d : last_good;
        e.cyc    = cyc + PULSE_LAT;
        if (stop) last_good = d;
        sb_q.push_back(e);
      end
      repeat (CLK_GOAL - 1) @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    uart_rxd = 1'b1;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every result pulse.
  always @(negedge clk) begin
    if (rx_done || frame_err) begin
      check("pulse_exclusive", 32'(rx_done & frame_err), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
        check("data_out", 32'(uart_data_out), 32'(e.data));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    exp_t e;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(uart_data_out), 32'h00);
    check("reset_done", 32'(rx_done), 32'd0);
    check("reset_err", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single byte
    send_frame(8'h55, 1'b1);
    idle(500);

    // Back-to-back, no idle gap
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle(500);

    // Glitch: 100 cycles low must be rejected
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    repeat (100) @(posedge clk);
    idle(5000);

    // Framing error after a good byte
    send_frame(8'h3C, 1'b1);
    send_frame(8'hFF, 1'b0);
    idle(2 * CLK_GOAL);

    // Break: 20 bit times low gives a single frame_err
    @(posedge clk); #1;
    uart_rxd = 1'b0;
    e.is_err = 1'b1;
    e.data   = last_good;
    e.cyc    = cyc + PULSE_LAT;
    sb_q.push_back(e);
    repeat (20 * CLK_GOAL) @(posedge clk);
    idle(3 * CLK_GOAL);
    send_frame(8'h81, 1'b1);
    idle(500);

    // Reset during data bit 4 of 0xC7
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'hC7, 1'b0};
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        uart_rxd = bits[i];
        repeat (CLK_GOAL - 1) @(posedge clk);
      end
    end
    #1;
    rst_n = 1'b0;
    #2;
    check("midreset_data", 32'(uart_data_out), 32'h00);
    check("midreset_done", 32'(rx_done), 32'd0);
    check("midreset_err", 32'(frame_err), 32'd0);
    last_good = 8'h00;
    uart_rxd = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(50);
    send_frame(8'h12, 1'b1);
    idle(600);

    // Drain: bounded wait for any outstanding expected pulse
    for (int i = 0; i < 6000 && sb_q.size() != 0; i++) @(posedge clk);
    check("pending_expected", 32'(sb_q.size()), 32'd0);
    check("final_data", 32'(uart_data_out), 32'h12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
